// File: rtl/prog_session_ctrl_if.sv
// Signal bundle for the programming session controller.
// Groups the programmer, CPU and shared-memory write ports.
interface prog_session_ctrl_if;
    logic        req;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        prog_enable;
    logic        prog_rst_n;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic [15:0] word_count;

    modport master (
        output req, prog_we, prog_addr, prog_data,
        output cpu_we, cpu_addr, cpu_data,
        input  mem_we, mem_addr, mem_data,
        input  prog_enable, prog_rst_n, cpu_rst_n,
        input  busy, done, word_count
    );

    modport slave (
        input  req, prog_we, prog_addr, prog_data,
        input  cpu_we, cpu_addr, cpu_data,
        output mem_we, mem_addr, mem_data,
        output prog_enable, prog_rst_n, cpu_rst_n,
        output busy, done, word_count
    );
endinterface

// File: rtl/prog_session_ctrl.sv
// Programming session controller: holds the CPU in reset while a
// UART programmer owns the shared memory write port.
module prog_session_ctrl #(
    parameter int unsigned HALT_CYCLES    = 16,
    parameter int unsigned IDLE_TIMEOUT   = 50_000_000,
    parameter int unsigned RELEASE_CYCLES = 16,
    parameter int unsigned MAX_WORDS      = 4096
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        prog_req_i,
    input  logic        prog_we_i,
    input  logic [31:0] prog_addr_i,
    input  logic [31:0] prog_data_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        prog_enable_o,
    output logic        prog_rst_no,
    output logic        cpu_rst_no,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] word_count_o
);

    localparam logic [31:0] HALT_LAST = 32'(HALT_CYCLES - 1);
    localparam logic [31:0] IDLE_LAST = 32'(IDLE_TIMEOUT - 1);
    localparam logic [31:0] REL_LAST  = 32'(RELEASE_CYCLES - 1);
    localparam logic [31:0] MAX_W     = 32'(MAX_WORDS);

    typedef enum logic [1:0] {IDLE, HALT, PROGRAM, RELEASE} state_t;
    typedef enum logic [1:0] {SEL_NONE, SEL_CPU, SEL_PROG} sel_t;

    state_t      state;
    state_t      state_d;
    sel_t        sel;
    logic [31:0] cnt;
    logic        armed;
    logic        abort;
    logic        at_max;
    logic        wr_ok;

    assign at_max = 32'(word_count_o) >= MAX_W;
    assign wr_ok  = prog_we_i && !at_max;

    // Next-state selection from the registered state and inputs.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (prog_req_i && armed) state_d = HALT;
            end
            HALT: begin
                if (cnt == HALT_LAST)
                    state_d = (abort || !prog_req_i) ? RELEASE : PROGRAM;
            end
            PROGRAM: begin
                if (!prog_req_i || at_max)
                    state_d = RELEASE;
                else if (word_count_o != 16'd0 && cnt == IDLE_LAST)
                    state_d = RELEASE;
            end
            RELEASE: begin
                if (cnt == REL_LAST) state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state         <= IDLE;
            sel           <= SEL_NONE;
            cnt           <= '0;
            armed         <= 1'b1;
            abort         <= 1'b0;
            done_o        <= 1'b0;
            word_count_o  <= '0;
            cpu_rst_no    <= 1'b0;
            prog_rst_no   <= 1'b0;
            prog_enable_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            state  <= state_d;
            done_o <= (state == RELEASE) && (state_d == IDLE);
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!prog_req_i) armed <= 1'b1;
                    if (state_d == HALT) begin
                        word_count_o <= '0;
                        abort        <= 1'b0;
                    end
                end
                HALT: begin
                    cnt <= (state_d != HALT) ? '0 : cnt + 32'd1;
                    if (!prog_req_i) abort <= 1'b1;
                end
                PROGRAM: begin
                    if (state_d != PROGRAM || prog_we_i)
                        cnt <= '0;
                    else if (cnt != IDLE_LAST)
                        cnt <= cnt + 32'd1;
                    if (wr_ok && word_count_o != 16'hFFFF)
                        word_count_o <= word_count_o + 16'd1;
                end
                RELEASE: begin
                    cnt <= (state_d != RELEASE) ? '0 : cnt + 32'd1;
                    if (state_d == IDLE) armed <= 1'b0;
                end
            endcase
            unique case (state_d)
                IDLE: begin
                    sel <= SEL_CPU;
                    {cpu_rst_no, prog_rst_no, prog_enable_o, busy_o} <= 4'b1100;
                end
                HALT: begin
                    sel <= SEL_NONE;
                    {cpu_rst_no, prog_rst_no, prog_enable_o, busy_o} <= 4'b0001;
                end
                PROGRAM: begin
                    sel <= SEL_PROG;
                    {cpu_rst_no, prog_rst_no, prog_enable_o, busy_o} <= 4'b0111;
                end
                RELEASE: begin
                    sel <= SEL_NONE;
                    {cpu_rst_no, prog_rst_no, prog_enable_o, busy_o} <= 4'b0101;
                end
            endcase
        end
    end

    // Memory port mux steered only by the registered owner select.
    always_comb begin
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        case (sel)
            SEL_CPU: begin
                mem_we_o   = cpu_we_i;
                mem_addr_o = cpu_addr_i;
                mem_data_o = cpu_data_i;
            end
            SEL_PROG: begin
                mem_we_o   = wr_ok;
                mem_addr_o = prog_addr_i;
                mem_data_o = prog_data_i;
            end
            default: ;
        endcase
    end

endmodule
